lsu_mem_stage: RTL

- Load/store sequencer between the pipeline's execute stage and the 8-bit DataMemory. It drives DataMemory's mem_read, mem_write, addr and wdata ports and consumes its rdata.
- Accepts one byte or 16-bit word request per valid/ready handshake.
- Splits a word access into two byte accesses, little-endian.
- Absorbs DataMemory's 1-cycle registered read latency.
- Returns load data with its destination register tag to writeback.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_mem_stage_if.sv | 46 ++++
 rtl/DataMemory.sv | 25 ++
 rtl/lsu_mem_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory stage.
// The FSM state enum, opcode/size encodings and byte-extension helper live here.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L_LO,
        L_HI,
        L_CAP,
        S_LO,
        S_HI
    } lsu_state_e;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;
    localparam logic SZ_BYTE  = 1'b0;
    localparam logic SZ_WORD  = 1'b1;

    function automatic logic [15:0] sext8to16(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Bundle of request, writeback and DataMemory signals around lsu_mem_stage.
// slave = the LSU itself, master = the execute-side requester, mem = the byte memory.
interface lsu_mem_stage_if #(
    parameter int ADDR_W = 8,
    parameter int RD_W   = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_word;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic [RD_W-1:0]   req_rd;

    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [15:0]       wb_data;
    logic              store_done;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req_valid, req_write, req_word, req_signed, req_addr, req_wdata, req_rd,
        output req_ready,
        output wb_valid, wb_rd, wb_data, store_done,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_write, req_word, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  wb_valid, wb_rd, wb_data, store_done
    );

    modport mem (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/DataMemory.sv
// 8-bit wide single-port data memory with a one-cycle registered read.
// rdata updates only on a read edge and holds otherwise.
module DataMemory #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem_q[addr] <= wdata;
        end
        if (mem_read) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store sequencer: splits 16-bit accesses into little-endian byte accesses
// on the 8-bit DataMemory and hides its one-cycle read latency from writeback.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_W   = 3
) (
    input logic           clk,
    input logic           rst_n,
    lsu_mem_stage_if.slave bus
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_hi_q, wdata_hi_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              word_q, word_d;
    logic              signed_q, signed_d;
    logic [7:0]        lo_q, lo_d;

    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [15:0]       wb_data_q, wb_data_d;
    logic              store_done_q, store_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_hi_q   <= '0;
            rd_q         <= '0;
            word_q       <= 1'b0;
            signed_q     <= 1'b0;
            lo_q         <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_hi_q   <= wdata_hi_d;
            rd_q         <= rd_d;
            word_q       <= word_d;
            signed_q     <= signed_d;
            lo_q         <= lo_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_hi_d   = wdata_hi_q;
        rd_d         = rd_q;
        word_d       = word_q;
        signed_d     = signed_q;
        lo_d         = lo_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        store_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    wdata_hi_d = bus.req_wdata[15:8];
                    rd_d       = bus.req_rd;
                    word_d     = bus.req_word;
                    signed_d   = bus.req_signed;
                    mem_addr_d = bus.req_addr;
                    if (bus.req_write == OP_STORE) begin
                        mem_wdata_d = bus.req_wdata[7:0];
                        mem_write_d = 1'b1;
                        state_d     = S_LO;
                    end else begin
                        mem_read_d = 1'b1;
                        state_d    = L_LO;
                    end
                end
            end
            L_LO: begin
                if (word_q == SZ_WORD) begin
                    mem_addr_d = addr_q + ADDR_W'(1);
                    state_d    = L_HI;
                end else begin
                    mem_read_d = 1'b0;
                    state_d    = L_CAP;
                end
            end
            L_HI: begin
                // Low byte arrives now; the high byte follows one cycle later.
                lo_d       = bus.mem_rdata;
                mem_read_d = 1'b0;
                state_d    = L_CAP;
            end
            L_CAP: begin
                if (word_q == SZ_WORD) begin
                    wb_data_d = {bus.mem_rdata, lo_q};
                end else if (signed_q) begin
                    wb_data_d = sext8to16(bus.mem_rdata);
                end else begin
                    wb_data_d = {8'h00, bus.mem_rdata};
                end
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                state_d    = IDLE;
            end
            S_LO: begin
                if (word_q == SZ_WORD) begin
                    mem_addr_d  = addr_q + ADDR_W'(1);
                    mem_wdata_d = wdata_hi_q;
                    state_d     = S_HI;
                end else begin
                    mem_write_d  = 1'b0;
                    store_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            S_HI: begin
                mem_write_d  = 1'b0;
                store_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.store_done = store_done_q;

endmodule
